// File: rtl/crypto_pkg.sv
// -----------------------------------------------------------------------------
// crypto_pkg
//   Shared definitions for the ALU sequencer and the 8-bit ALU it drives:
//   ALU opcodes, instruction opcodes, instruction field positions, the
//   sequencer FSM state encoding and a small opcode classifier.
// -----------------------------------------------------------------------------
package crypto_pkg;

  // Instruction layout: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
  localparam int INSTR_W = 16;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 10;
  localparam int RS_HI   = 9;
  localparam int RS_LO   = 8;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  localparam int NUM_REGS = 4;

  // ALU opcodes (the ALU itself decodes these)
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MOV = 4'h4;

  // Instruction opcodes; immediate forms set bit 3 on top of the ALU opcode
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_SUBI = 4'hA;
  localparam logic [3:0] OP_XORI = 4'hB;
  localparam logic [3:0] OP_MOVI = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_e;

  typedef enum logic [2:0] {
    K_NOP     = 3'd0,
    K_ALU_REG = 3'd1,
    K_ALU_IMM = 3'd2,
    K_HALT    = 3'd3,
    K_ILLEGAL = 3'd4
  } instr_kind_e;

  function automatic instr_kind_e decode_kind(input logic [3:0] op);
    instr_kind_e kind;
    case (op)
      OP_NOP:                         kind = K_NOP;
      OP_ADD, OP_SUB, OP_XOR, OP_MOV: kind = K_ALU_REG;
      OP_ADDI, OP_SUBI, OP_XORI,
      OP_MOVI:                        kind = K_ALU_IMM;
      OP_HALT:                        kind = K_HALT;
      default:                        kind = K_ILLEGAL;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// -----------------------------------------------------------------------------
// alu_seq_regfile
//   4 x DATA_W register file: one synchronous write port, three combinational
//   read ports (rd, rs, debug). Synchronous active-high reset clears all
//   registers.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   wr_en/addr/data     write port (takes effect at the rising edge)
//   rd_addr/rd_data     read port for the destination operand
//   rs_addr/rs_data     read port for the source operand
//   dbg_addr/dbg_data   debug read port
// -----------------------------------------------------------------------------
module alu_seq_regfile
  import crypto_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [1:0]        rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // NOTE: the array is reset explicitly because software relies on R0..R3
  // reading zero after reset; this is only four flops wide, not a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data  = mem_q[rd_addr];
  assign rs_data  = mem_q[rs_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Control stage in front of the 8-bit combinational ALU. Fetches 16-bit
//   instructions over valid/ready, reads operands from a 4x8 register file,
//   presents registered A/B/opcode to the ALU and writes the result back.
//   One instruction every three cycles: FETCH -> EXEC -> WB.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start                     leave IDLE/HALT and begin fetching
//   instr_valid/ready/data    instruction handshake
//   alu_a, alu_b, alu_op      registered ALU operands/opcode
//   alu_result                combinational ALU result
//   dbg_addr/dbg_data         debug register read
//   busy, halted, illegal     status (illegal is a 1-cycle pulse)
//   retired                   retired-instruction counter (wraps)
//   zero_flag                 only when ALU_SEQ_ZFLAG_EN is defined
// Configuration
//   ALU_SEQ_ZFLAG_EN          builds the zero flag register and port
// -----------------------------------------------------------------------------
module alu_sequencer
  import crypto_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [15:0]        instr_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [3:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [1:0]         dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic               zero_flag
`endif
);

  seq_state_e        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        rd_q, rd_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
`ifdef ALU_SEQ_ZFLAG_EN
  logic              zflag_q, zflag_d;
`endif

  logic [3:0]        fetch_op;
  logic [1:0]        fetch_rd, fetch_rs;
  logic [7:0]        fetch_imm;
  instr_kind_e       fetch_kind, wb_kind;
  logic [DATA_W-1:0] rd_data, rs_data;
  logic              wr_en;

  assign fetch_op   = instr_data[OP_HI:OP_LO];
  assign fetch_rd   = instr_data[RD_HI:RD_LO];
  assign fetch_rs   = instr_data[RS_HI:RS_LO];
  assign fetch_imm  = instr_data[IMM_HI:IMM_LO];
  assign fetch_kind = decode_kind(fetch_op);
  assign wb_kind    = decode_kind(op_q);

  // Operands are read with the fetch-time rd/rs; the write of the previous
  // instruction landed at the end of its WB, before this FETCH, so no
  // forwarding is needed.
  alu_seq_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (rd_q),
    .wr_data  (alu_result),
    .rd_addr  (fetch_rd),
    .rd_data  (rd_data),
    .rs_addr  (fetch_rs),
    .rs_data  (rs_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // NOTE: every signal gets its default (hold or idle) value first so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    illegal_d = 1'b0;
    retired_d = retired_q;
    wr_en     = 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
    zflag_d   = zflag_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (instr_valid) begin
          op_d    = fetch_op;
          rd_d    = fetch_rd;
          state_d = ST_EXEC;
          // Operands are registered here so they are stable for EXEC and WB;
          // non-ALU instructions leave the ALU inputs untouched.
          if (fetch_kind == K_ALU_REG || fetch_kind == K_ALU_IMM) begin
            alu_a_d  = rd_data;
            alu_b_d  = (fetch_kind == K_ALU_IMM) ? DATA_W'(fetch_imm) : rs_data;
            alu_op_d = {1'b0, fetch_op[2:0]};
          end
        end
      end

      ST_EXEC: begin
        state_d = ST_WB;
        // Registered so the pulse lines up with the WB cycle.
        if (wb_kind == K_ILLEGAL) illegal_d = 1'b1;
      end

      ST_WB: begin
        state_d = ST_FETCH;
        unique case (wb_kind)
          K_ALU_REG, K_ALU_IMM: begin
            wr_en     = 1'b1;
            retired_d = retired_q + CNT_W'(1);
`ifdef ALU_SEQ_ZFLAG_EN
            zflag_d   = (alu_result == '0);
`endif
          end
          K_NOP: begin
            retired_d = retired_q + CNT_W'(1);
          end
          K_HALT: begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = ST_HALT;
          end
          default: ; // illegal: no write, not retired
        endcase
      end

      ST_HALT: begin
        if (start) state_d = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      rd_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
`ifdef ALU_SEQ_ZFLAG_EN
      zflag_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
`ifdef ALU_SEQ_ZFLAG_EN
      zflag_q   <= zflag_d;
`endif
    end
  end

  assign instr_ready = (state_q == ST_FETCH);
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_WB);
  assign halted      = (state_q == ST_HALT);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;
`ifdef ALU_SEQ_ZFLAG_EN
  assign zero_flag   = zflag_q;
`endif

endmodule
